// File: rtl/tour_pkg.sv
// Shared constants and FSM state type for the knight's-tour command sequencer.
package tour_pkg;

  // Command opcodes (cmd[15:12])
  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_MOVE_FF = 4'b0011;

  // Headings (cmd[11:4])
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes toward the UART
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } tour_state_t;

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command-processor handshake bundle: command word, valid, consume/finish
// strobes and the response byte.
interface tour_cmd_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  // Sequencer side
  modport master (
    output cmd, cmd_rdy, resp,
    input  clr_cmd_rdy, send_resp
  );

  // Command-processor side
  modport slave (
    input  cmd, cmd_rdy, resp,
    output clr_cmd_rdy, send_resp
  );
endinterface

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal motion command.
// Optional macro TOUR_FANFARE_EN: horizontal command uses the fanfare opcode.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HORZ_OP = OP_MOVE_FF;
`else
  localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

  logic [7:0] v_hdg, h_hdg;
  logic [3:0] v_sq,  h_sq;

  // Priority decode: the lowest set bit selects the (dx,dy) pair.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    v_hdg = HDG_N;
    v_sq  = 4'd0;
    h_hdg = HDG_N;
    h_sq  = 4'd0;
    casez (move)
      8'b???????1: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end // (+1,+2)
      8'b??????10: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end // (-1,+2)
      8'b?????100: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end // (-2,+1)
      8'b????1000: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end // (-2,-1)
      8'b???10000: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end // (-1,-2)
      8'b??100000: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end // (+1,-2)
      8'b?1000000: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end // (+2,-1)
      8'b10000000: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end // (+2,+1)
      default:     ; // no move: zero squares, heading north for both
    endcase
  end

  assign vert_cmd = {OP_MOVE, v_hdg, v_sq};
  assign horz_cmd = {HORZ_OP, h_hdg, h_sq};

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: walks the solver's move list and issues a
// vertical then a horizontal move command per step; passes UART commands
// through while idle. Optional macro TOUR_FANFARE_EN (see tour_move_decode).
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_tour,
  input  logic [7:0]         move,
  output logic [IDX_W-1:0]   mv_indx,
  input  logic [15:0]        cmd_UART,
  input  logic               cmd_rdy_UART,
  tour_cmd_seq_if.master     bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_t      state, state_nxt;
  logic [IDX_W-1:0] indx_nxt;
  logic [15:0]      vert_cmd, horz_cmd;
  logic             last_move;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_move = (mv_indx == LAST_IDX);

  // State and move-index registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous, so it sits in the sensitivity list and is
    // tested first; state returns to IDLE without waiting for a clock edge.
    if (rst) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples its pre-edge inputs, independent of statement order.
      state   <= state_nxt;
      mv_indx <= indx_nxt;
    end
  end

  // Next state, next index and the command-bus outputs.
  always_comb begin
    state_nxt   = state;
    indx_nxt    = mv_indx;
    bus.cmd     = cmd_UART;
    bus.cmd_rdy = cmd_rdy_UART;
    bus.resp    = RESP_ACK;
    unique case (state)
      IDLE: begin
        if (start_tour) begin
          state_nxt = VERT;
          indx_nxt  = '0;
        end
      end
      VERT: begin
        bus.cmd     = vert_cmd;
        bus.cmd_rdy = 1'b1;
        bus.resp    = RESP_POS;
        // clr_cmd_rdy wins over a coincident send_resp, which is dropped.
        if (bus.clr_cmd_rdy) state_nxt = HOLD_V;
      end
      HOLD_V: begin
        bus.cmd     = vert_cmd;
        bus.cmd_rdy = 1'b0;
        bus.resp    = RESP_POS;
        if (bus.send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b1;
        bus.resp    = RESP_POS;
        if (bus.clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b0;
        bus.resp    = last_move ? RESP_ACK : RESP_POS;
        if (bus.send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
            indx_nxt  = '0;
          end else begin
            state_nxt = VERT;
            indx_nxt  = mv_indx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sits directly downstream of the knight's-tour solver.
- Once the solver asserts done and start_tour arrives, it walks the stored move list by driving mv_indx into the solver's indx input.
- Each one-hot knight move is split into a vertical motion command followed by a horizontal one, issued to the command processor through the cmd/cmd_rdy/clr_cmd_rdy/send_resp handshake.
- When idle it passes UART commands through unchanged.

Parameters:
NUM_MOVES, 24, moves in a tour (5x5 board minus start square); last index = NUM_MOVES-1
IDX_W, 5, width of mv_indx

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_tour  in  1  one-cycle pulse; begin issuing the tour
move  in  8  one-hot move at mv_indx, from solver (combinational read)
mv_indx  out  IDX_W  move index to solver indx
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy  in  1  command processor has consumed cmd
send_resp  in  1  command processor finished executing cmd
cmd  out  16  muxed command {opcode[15:12], heading[11:4], squares[3:0]}
cmd_rdy  out  1  cmd valid
resp  out  8  response byte for UART

Behaviour:
- Reset (async, rst=1): state IDLE, mv_indx=0.
- In IDLE the outputs are cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- Move decode, with (dx,dy) per bit:
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
  - Lowest set bit wins.
  - move==0 gives squares=0, heading north for both commands.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - Vertical command uses dy>0 north, else south, squares=|dy|.
  - Horizontal command uses dx>0 east, else west, squares=|dx|.
- Opcode 4'b0010 (move) for both commands, except as noted under Optional Feature.
- FSM states: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: start_tour -> VERT with mv_indx=0. cmd_rdy goes high on the first cycle after the capturing edge.
  - VERT: cmd=vertical command, cmd_rdy=1. clr_cmd_rdy -> HOLD_V.
  - HOLD_V: cmd_rdy=0, cmd held. send_resp -> HORZ.
  - HORZ: cmd=horizontal command, cmd_rdy=1. clr_cmd_rdy -> HOLD_H.
  - HOLD_H: cmd_rdy=0. On send_resp:
    - if mv_indx==NUM_MOVES-1: go to IDLE and clear mv_indx to 0;
    - else increment mv_indx and go to VERT.
- resp while touring is 8'h5A, except in HOLD_H with mv_indx==NUM_MOVES-1, where it is 8'hA5 (final ack).
- cmd and cmd_rdy are combinational from state, mv_indx and move; mv_indx is registered.
- Boundary cases:
  - start_tour outside IDLE: ignored.
  - cmd_rdy_UART during a tour: ignored, not forwarded.
  - clr_cmd_rdy and send_resp together in VERT/HORZ: only clr_cmd_rdy acts; the state advances to HOLD_*, and send_resp must then be asserted again.
  - send_resp in VERT/HORZ: ignored.
  - clr_cmd_rdy in HOLD_*: ignored.
  - mv_indx never exceeds NUM_MOVES-1.
  - Reset mid-tour: immediate return to IDLE, mv_indx=0, UART pass-through restored.

Optional Feature:
- Macro TOUR_FANFARE_EN.
- Defined: the horizontal command opcode is 4'b0011 (move with fanfare); vertical stays 4'b0010.
- Undefined: both commands use 4'b0010.

Decomposition:
- Package tour_pkg holds:
  - opcode constants (OP_MOVE 4'b0010, OP_MOVE_FF 4'b0011);
  - heading constants HDG_N/W/S/E;
  - RESP_ACK 8'hA5 and RESP_POS 8'h5A;
  - the FSM state enum typedef.
- Sub-module tour_move_decode: purely combinational, move[7:0] -> vert_cmd[15:0], horz_cmd[15:0].

Test Plan:
- Idle pass-through: cmd_UART=16'h2_00_1, cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1, resp=8'hA5.
- move=8'h01 (b0), start_tour, then clr_cmd_rdy and send_resp.
  - First cmd=16'h2002 (north, 2 squares).
  - Second cmd=16'h2BF1 (east, 1), or 16'h3BF1 with TOUR_FANFARE_EN.
  - mv_indx becomes 1.
- move=8'h08 (b3): vertical 16'h27F1 (south, 1), horizontal 16'h23F2 (west, 2).
- Full tour with an auto-responding model: exactly 48 cmd_rdy pulses, mv_indx 0..23.
  - resp=8'h5A throughout, and 8'hA5 in the final HOLD_H.
  - Return to IDLE with mv_indx=0.
- Same-cycle clr_cmd_rdy+send_resp in VERT -> HOLD_V, no advance to HORZ until a later send_resp.
- rst pulsed in HOLD_H at mv_indx=10 -> IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART next cycle; a second start_tour restarts from index 0.
